sram_island_ctrl: RTL and testbench

- AHB slave-side sequencer for the SRAM subsystem; one instance drives the per-island enable generators.
- Decodes the target voltage island from the address.
- Pipelines writes into the data phase and issues reads in the address phase.
- Detects same-island read-after-write conflicts. It stalls the bus one cycle and replays the read from the stored address. It also returns read data and AHB responses.

---
 rtl/sram_ss_pkg.sv | 24 ++
 rtl/sram_island_ctrl_if.sv | 22 ++
 rtl/sram_rdata_mux.sv | 17 +
 rtl/sram_island_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_island_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ss_pkg.sv
// Shared types and constants for the SRAM subsystem sequencer.
package sram_ss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_D      = 3'd1,
    ST_RD_D      = 3'd2,
    ST_CONF_WAIT = 3'd3,
    ST_CONF_DATA = 3'd4,
    ST_ERR1      = 3'd5,
    ST_ERR2      = 3'd6
  } state_t;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] SIZE_BYTE     = 3'b000;
  localparam logic [2:0] SIZE_HALF     = 3'b001;
  localparam logic [2:0] SIZE_WORD     = 3'b010;

endpackage

// File: rtl/sram_island_ctrl_if.sv
// AHB slave-side bus bundle seen by the SRAM island sequencer.
interface sram_island_ctrl_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hready,
    input  hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/sram_rdata_mux.sv
// NUM_ISL-way 32-bit read-data select; drives zero when not enabled.
module sram_rdata_mux #(
  parameter int NUM_ISL = 4,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_ISL*32-1:0] rdata,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [31:0]           dout
);

  always_comb begin
    dout = '0;
    if (en) dout = rdata[32*int'(sel) +: 32];
  end

endmodule

// File: rtl/sram_island_ctrl.sv
// AHB slave sequencer for the SRAM islands: write data-phase pipelining,
// address-phase reads and same-island read-after-write replay.
//
// state        | meaning
// ST_IDLE      | no data phase in progress
// ST_WR_D      | write data phase to reg_isl
// ST_RD_D      | read data phase, hrdata from reg_isl
// ST_CONF_WAIT | replayed read issued from haddr_reg, bus stalled
// ST_CONF_DATA | replayed read data returned
// ST_ERR1      | first error cycle (wait)
// ST_ERR2      | second error cycle (ready)
module sram_island_ctrl
  import sram_ss_pkg::*;
#(
  parameter int NUM_ISL = 4,
  parameter int ISL_LSB = 14
) (
  input  logic                  hclk,
  input  logic                  hreset,
  sram_island_ctrl_if.slave     ahb,
  input  logic [NUM_ISL*32-1:0] sram_rdata,
  output logic [31:0]           haddr_reg,
  output logic [2:0]            hsize_reg,
  output logic [NUM_ISL-1:0]    wr_dphase,
  output logic [NUM_ISL-1:0]    rd_aphase,
  output logic [NUM_ISL-1:0]    rd_dphase,
  output logic                  RW_conf_dphase
);

  localparam int ISL_W = $clog2(NUM_ISL);

  state_t            state;
  state_t            state_nxt;
  logic [ISL_W-1:0]  reg_isl;
  logic [ISL_W-1:0]  isl;
  logic              ready_st;
  logic              active;
  logic              acc;
  logic              legal;
  logic              conflict;
  logic              rdata_en;
  logic [31:0]       rd_word;

  assign isl      = ahb.haddr[ISL_LSB +: ISL_W];
  assign active   = (ahb.htrans == HTRANS_NONSEQ) || (ahb.htrans == HTRANS_SEQ);
  // Stall states never accept, even if the bus-wide hready misbehaves.
  assign ready_st = (state != ST_CONF_WAIT) && (state != ST_ERR1);
  assign acc      = ahb.hsel && ahb.hready && active && ready_st;

  assign legal = (ahb.hsize == SIZE_BYTE) ||
                 ((ahb.hsize == SIZE_HALF) && !ahb.haddr[0]) ||
                 ((ahb.hsize == SIZE_WORD) && (ahb.haddr[1:0] == 2'b00));

  assign conflict = acc && legal && !ahb.hwrite && (state == ST_WR_D) && (isl == reg_isl);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      reg_isl   <= '0;
      haddr_reg <= '0;
      hsize_reg <= '0;
    end else begin
      state <= state_nxt;
      if (acc && legal) reg_isl <= isl;
      if (acc && legal && (ahb.hwrite || conflict)) begin
        haddr_reg <= ahb.haddr;
        hsize_reg <= ahb.hsize;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    ahb.hreadyout  = 1'b1;
    ahb.hresp      = HRESP_OKAY;
    wr_dphase      = '0;
    rd_aphase      = '0;
    rd_dphase      = '0;
    RW_conf_dphase = 1'b0;
    rdata_en       = 1'b0;

    case (state)
      ST_CONF_WAIT: state_nxt = ST_CONF_DATA;
      ST_ERR1:      state_nxt = ST_ERR2;
      default: begin
        if (!acc)             state_nxt = ST_IDLE;
        else if (!legal)      state_nxt = ST_ERR1;
        else if (ahb.hwrite)  state_nxt = ST_WR_D;
        else if (conflict)    state_nxt = ST_CONF_WAIT;
        else                  state_nxt = ST_RD_D;
      end
    endcase

    case (state)
      ST_WR_D: wr_dphase[reg_isl] = 1'b1;
      ST_RD_D: begin
        rd_dphase[reg_isl] = 1'b1;
        rdata_en           = 1'b1;
      end
      ST_CONF_WAIT: begin
        ahb.hreadyout      = 1'b0;
        rd_dphase[reg_isl] = 1'b1;
        RW_conf_dphase     = 1'b1;
      end
      ST_CONF_DATA: rdata_en = 1'b1;
      ST_ERR1: begin
        ahb.hreadyout = 1'b0;
        ahb.hresp     = HRESP_ERROR;
      end
      ST_ERR2: ahb.hresp = HRESP_ERROR;
      default: ;
    endcase

    if (acc && legal && !ahb.hwrite && !conflict) rd_aphase[isl] = 1'b1;
  end

  sram_rdata_mux #(
    .NUM_ISL (NUM_ISL),
    .SEL_W   (ISL_W)
  ) u_rdata_mux (
    .rdata (sram_rdata),
    .sel   (reg_isl),
    .en    (rdata_en),
    .dout  (rd_word)
  );

  assign ahb.hrdata = rd_word;

endmodule

// File: tb/tb_sram_island_ctrl.sv
// Scoreboard bench for sram_island_ctrl: driver predicts, negedge monitor compares.
`timescale 1ns/1ps
module tb_sram_island_ctrl;
  import sram_ss_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] sram_rdata;
  logic [31:0]  haddr_reg;
  logic [2:0]   hsize_reg;
  logic [3:0]   wr_dphase, rd_aphase, rd_dphase;
  logic         rw_conf;

  sram_island_ctrl_if ahb();
  assign ahb.hready = ahb.hreadyout;

  sram_island_ctrl #(.NUM_ISL(4), .ISL_LSB(14)) dut (
    .hclk           (clk),
    .hreset         (rst),
    .ahb            (ahb),
    .sram_rdata     (sram_rdata),
    .haddr_reg      (haddr_reg),
    .hsize_reg      (hsize_reg),
    .wr_dphase      (wr_dphase),
    .rd_aphase      (rd_aphase),
    .rd_dphase      (rd_dphase),
    .RW_conf_dphase (rw_conf)
  );

  always #5 clk = ~clk;

  typedef enum int {K_WR, K_RD, K_CONF, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    int          isl;
    logic [31:0] addr;
    logic [2:0]  size;
  } exp_t;

  exp_t       dq[$];
  logic [3:0] aq[$];
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 0;
  bit  pend_conf = 0;
  bit  pend_err = 0;
  int  conf_isl = 0;
  bit  prev_wr_valid = 0;
  int  prev_wr_isl = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal when size is at most a word and the address is a multiple of the size in bytes.
  function automatic bit ref_legal(input logic [2:0] size, input logic [31:0] a);
    if (size > 3'd2) return 1'b0;
    return (a % (32'd1 << size)) == 0;
  endfunction

  function automatic logic [31:0] slice(input int i);
    return sram_rdata[32*i +: 32];
  endfunction

  task automatic mon_step();
    exp_t       e;
    logic [3:0] ea;
    if (ahb.hsel && ahb.hready && ahb.htrans[1]) begin
      if (aq.size() == 0) begin
        tests++; fails++;
        $display("FAIL aphase_unexpected: accept with no pending transfer at %0t", $time);
      end else begin
        ea = aq.pop_front();
        chk("rd_aphase", 32'(rd_aphase), 32'(ea));
      end
    end else begin
      chk("rd_aphase_noacc", 32'(rd_aphase), 32'd0);
    end

    if (pend_conf) begin
      pend_conf = 0;
      chk("conf_data_ready", 32'(ahb.hreadyout), 32'd1);
      chk("conf_data_hrdata", ahb.hrdata, slice(conf_isl));
      chk("conf_data_rd_dphase", 32'(rd_dphase), 32'd0);
      chk("conf_data_rw_conf", 32'(rw_conf), 32'd0);
    end else if (pend_err) begin
      pend_err = 0;
      chk("err2_hresp", 32'(ahb.hresp), 32'(HRESP_ERROR));
      chk("err2_ready", 32'(ahb.hreadyout), 32'd1);
      chk("err2_strobes", {24'd0, wr_dphase, rd_dphase}, 32'd0);
    end else if (wr_dphase != 0 || rd_dphase != 0 || ahb.hresp != 2'b00 || !ahb.hreadyout) begin
      if (dq.size() == 0) begin
        tests++; fails++;
        $display("FAIL dphase_unexpected: wr=%b rd=%b hresp=%b rdy=%b with nothing expected at %0t",
                 wr_dphase, rd_dphase, ahb.hresp, ahb.hreadyout, $time);
      end else begin
        e = dq.pop_front();
        case (e.kind)
          K_WR: begin
            chk("wr_dphase", 32'(wr_dphase), 32'd1 << e.isl);
            chk("wr_rd_dphase", 32'(rd_dphase), 32'd0);
            chk("wr_haddr_reg", haddr_reg, e.addr);
            chk("wr_hsize_reg", 32'(hsize_reg), 32'(e.size));
            chk("wr_ready", 32'(ahb.hreadyout), 32'd1);
            chk("wr_hresp", 32'(ahb.hresp), 32'd0);
          end
          K_RD: begin
            chk("rd_dphase", 32'(rd_dphase), 32'd1 << e.isl);
            chk("rd_wr_dphase", 32'(wr_dphase), 32'd0);
            chk("rd_rw_conf", 32'(rw_conf), 32'd0);
            chk("rd_ready", 32'(ahb.hreadyout), 32'd1);
            chk("rd_hresp", 32'(ahb.hresp), 32'd0);
            chk("rd_hrdata", ahb.hrdata, slice(e.isl));
          end
          K_CONF: begin
            chk("conf_wait_ready", 32'(ahb.hreadyout), 32'd0);
            chk("conf_wait_rd_dphase", 32'(rd_dphase), 32'd1 << e.isl);
            chk("conf_wait_rw_conf", 32'(rw_conf), 32'd1);
            chk("conf_wait_haddr_reg", haddr_reg, e.addr);
            chk("conf_wait_hsize_reg", 32'(hsize_reg), 32'(e.size));
            pend_conf = 1;
            conf_isl  = e.isl;
          end
          default: begin
            chk("err1_ready", 32'(ahb.hreadyout), 32'd0);
            chk("err1_hresp", 32'(ahb.hresp), 32'(HRESP_ERROR));
            chk("err1_strobes", {24'd0, wr_dphase, rd_dphase}, 32'd0);
            pend_err = 1;
          end
        endcase
      end
    end else begin
      chk("idle_hrdata", ahb.hrdata, 32'd0);
    end
  endtask

  always @(negedge clk) if (mon_en) mon_step();

  initial begin
    sram_rdata = {$urandom, $urandom, $urandom, $urandom};
    forever begin
      @(posedge clk); #1;
      sram_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Called just after a rising edge; returns just after the edge that ends the address phase.
  task automatic do_xfer(input bit sel, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [1:0] trans);
    bit   lg, cf;
    int   isl, n;
    exp_t e;
    ahb.hsel = sel; ahb.haddr = addr; ahb.htrans = trans;
    ahb.hwrite = wr; ahb.hsize = size;
    if (sel && trans[1]) begin
      lg  = ref_legal(size, addr);
      isl = int'(addr[15:14]);
      cf  = lg && !wr && prev_wr_valid && (prev_wr_isl == isl);
      aq.push_back((lg && !wr && !cf) ? 4'(1 << isl) : 4'b0000);
      e.kind = !lg ? K_ERR : (wr ? K_WR : (cf ? K_CONF : K_RD));
      e.isl = isl; e.addr = addr; e.size = size;
      n = 0;
      @(negedge clk);
      while (!ahb.hreadyout && n < 4) begin
        n++;
        @(negedge clk);
      end
      if (!ahb.hreadyout) begin
        tests++; fails++;
        $display("FAIL accept_timeout: addr %h not accepted within 5 cycles", addr);
      end
      dq.push_back(e);
      prev_wr_valid = lg && wr;
      prev_wr_isl   = isl;
    end else begin
      @(negedge clk);
      prev_wr_valid = 0;
    end
    @(posedge clk); #1;
    ahb.hsel = 1'b0; ahb.htrans = 2'b00; ahb.hwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_xfer(1'b0, 1'b0, 32'd0, SIZE_WORD, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r, isl, last_isl, low, sz;
    bit wr;
    logic [31:0] tmp, addr;

    ahb.hsel = 0; ahb.haddr = 0; ahb.htrans = 2'b00; ahb.hwrite = 0; ahb.hsize = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_ready", 32'(ahb.hreadyout), 32'd1);
    chk("reset_hresp", 32'(ahb.hresp), 32'd0);
    chk("reset_hrdata", ahb.hrdata, 32'd0);
    chk("reset_haddr_reg", haddr_reg, 32'd0);
    chk("reset_hsize_reg", 32'(hsize_reg), 32'd0);
    chk("reset_strobes", {19'd0, rw_conf, wr_dphase, rd_aphase, rd_dphase}, 32'd0);
    mon_en = 1;
    @(posedge clk); #1;

    // Write island 1, then read island 0 concurrently with its data phase.
    do_xfer(1, 1, 32'h0000_4008, SIZE_WORD, HTRANS_NONSEQ);
    do_xfer(1, 0, 32'h0000_0010, SIZE_WORD, HTRANS_NONSEQ);
    idle(2);
    // Same-island read-after-write replay.
    do_xfer(1, 1, 32'h0000_4000, SIZE_WORD, HTRANS_NONSEQ);
    do_xfer(1, 0, 32'h0000_4004, SIZE_WORD, HTRANS_NONSEQ);
    idle(3);
    // Back-to-back writes to island 3.
    do_xfer(1, 1, 32'h0000_C000, SIZE_WORD, HTRANS_NONSEQ);
    do_xfer(1, 1, 32'h0000_C004, SIZE_WORD, HTRANS_SEQ);
    do_xfer(1, 1, 32'h0000_C008, SIZE_WORD, HTRANS_SEQ);
    idle(2);
    // Misaligned halfword read, then BUSY with hsel high.
    do_xfer(1, 0, 32'h0000_0001, SIZE_HALF, HTRANS_NONSEQ);
    idle(3);
    do_xfer(1, 0, 32'h0000_0020, SIZE_WORD, 2'b01);
    idle(2);

    last_isl = 0;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 15) begin
        case ($urandom_range(0, 2))
          0: do_xfer(0, 1'($urandom_range(0, 1)), 32'h0000_4000, SIZE_WORD, HTRANS_NONSEQ);
          1: do_xfer(1, 0, 32'h0000_8000, SIZE_WORD, 2'b01);
          default: do_xfer(1, 1, 32'h0000_0000, SIZE_WORD, 2'b00);
        endcase
      end else begin
        wr  = 1'($urandom_range(0, 1));
        isl = $urandom_range(0, 1) ? last_isl : $urandom_range(0, 3);
        if (r < 25) begin
          case ($urandom_range(0, 2))
            0: begin sz = $urandom_range(3, 7); low = $urandom_range(0, 255) * 4; end
            1: begin sz = 1; low = $urandom_range(0, 255) * 2 + 1; end
            default: begin sz = 2; low = $urandom_range(0, 255) * 4 + $urandom_range(1, 3); end
          endcase
        end else begin
          sz  = $urandom_range(0, 2);
          low = $urandom_range(0, 1023) * 4 + ($urandom_range(0, 3) & ~((1 << sz) - 1));
        end
        tmp  = $urandom;
        addr = (tmp & 32'hFFFF_0000) | (32'(isl) << 14) | 32'(low);
        do_xfer(1, wr, addr, 3'(sz), $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ);
        last_isl = isl;
      end
    end
    idle(4);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("aq_drained", 32'(aq.size()), 32'd0);
    chk("no_pending", {30'd0, pend_conf, pend_err}, 32'd0);

    // Reset in the middle of a replayed read.
    mon_en = 0;
    ahb.hsel = 1; ahb.htrans = HTRANS_NONSEQ; ahb.hwrite = 1;
    ahb.haddr = 32'h0000_4000; ahb.hsize = SIZE_WORD;
    @(posedge clk); #1;
    ahb.hwrite = 0; ahb.haddr = 32'h0000_4004;
    @(posedge clk); #1;
    ahb.hsel = 0; ahb.htrans = 2'b00;
    @(negedge clk);
    chk("pre_reset_conf_wait", {29'd0, ahb.hreadyout, rw_conf, rd_dphase[1]}, 32'b011);
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midreset_ready", 32'(ahb.hreadyout), 32'd1);
    chk("midreset_hresp", 32'(ahb.hresp), 32'd0);
    chk("midreset_strobes", {19'd0, rw_conf, wr_dphase, rd_aphase, rd_dphase}, 32'd0);
    chk("midreset_haddr_reg", haddr_reg, 32'd0);
    chk("midreset_hrdata", ahb.hrdata, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
